// File: rtl/dma_lb_pkg.sv
// Shared definitions for the DMA loopback responder.
// Holds line/tag/address widths, the response code encoding and the
// constant response position value used by both channels.
package dma_lb_pkg;

  localparam int unsigned LineW    = 1024;
  localparam int unsigned BeW      = LineW / 8;
  localparam int unsigned TagW     = 6;
  localparam int unsigned NumTags  = 1 << TagW;
  localparam int unsigned EaW      = 64;
  localparam int unsigned NumLines = 16;
  localparam int unsigned IdxW     = 4;

  typedef enum logic [2:0] {
    RspOk      = 3'b000,
    RspAddrErr = 3'b010,
    RspDupTag  = 3'b100
  } rsp_code_e;

  // Every response covers a whole 128-byte line.
  localparam logic [1:0] PosFullLine = 2'b11;

endpackage

// File: rtl/dma_lb_delay_line.sv
// Fixed-latency response pipeline for one DMA channel.
// A response captured on in_valid_i appears on the out_* ports exactly Lat
// cycles later. Tag/code/data are zeroed when no response is captured so the
// outputs read as zero between responses.
//   clk_i, rst_ni : clock, asynchronous active-low reset (empties the pipe)
//   in_*_i        : response produced at command acceptance
//   out_*_o       : registered response, Lat cycles later
module dma_lb_delay_line
  import dma_lb_pkg::*;
#(
  parameter int unsigned Lat = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  input  logic [TagW-1:0]  in_tag_i,
  input  rsp_code_e        in_code_i,
  input  logic [LineW-1:0] in_data_i,
  output logic             out_valid_o,
  output logic [TagW-1:0]  out_tag_o,
  output rsp_code_e        out_code_o,
  output logic [LineW-1:0] out_data_o
);

  logic             valid_q [Lat];
  logic [TagW-1:0]  tag_q   [Lat];
  rsp_code_e        code_q  [Lat];
  logic [LineW-1:0] data_q  [Lat];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < Lat; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        code_q[i]  <= RspOk;
        data_q[i]  <= '0;
      end
    end else begin
      valid_q[0] <= in_valid_i;
      tag_q[0]   <= in_valid_i ? in_tag_i  : '0;
      code_q[0]  <= in_valid_i ? in_code_i : RspOk;
      data_q[0]  <= in_valid_i ? in_data_i : '0;
      for (int unsigned i = 1; i < Lat; i++) begin
        valid_q[i] <= valid_q[i-1];
        tag_q[i]   <= tag_q[i-1];
        code_q[i]  <= code_q[i-1];
        data_q[i]  <= data_q[i-1];
      end
    end
  end

  assign out_valid_o = valid_q[Lat-1];
  assign out_tag_o   = tag_q[Lat-1];
  assign out_code_o  = code_q[Lat-1];
  assign out_data_o  = data_q[Lat-1];

endmodule

// File: rtl/dma_loopback_responder.sv
// DMA loopback responder: emulates a 2 KB host memory window (16 lines of
// 128 bytes) behind independent write and read command channels.
// Commands are classified at acceptance (address window, duplicate tag),
// writes update memory and reads sample it at the acceptance edge, and each
// command gets exactly one response RSP_LAT cycles later, in order.
//   clk, rst_n          : clock, asynchronous active-low reset
//   dma_wr_cmd_*        : write commands (valid/ready, data, be, ea, tag)
//   dma_wr_resp_*       : write responses (no backpressure, data always zero)
//   dma_rd_cmd_*        : read commands (data/be ignored)
//   dma_rd_resp_*       : read responses carrying line contents
//   idle                : no command outstanding on either channel
module dma_loopback_responder
  import dma_lb_pkg::*;
#(
  parameter logic [52:0] BASE_EA = 53'h0,
  parameter int unsigned RSP_LAT = 4,
  parameter int unsigned MAX_OUT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             dma_wr_cmd_valid,
  output logic             dma_wr_cmd_ready,
  input  logic [LineW-1:0] dma_wr_cmd_data,
  input  logic [BeW-1:0]   dma_wr_cmd_be,
  input  logic [EaW-1:0]   dma_wr_cmd_ea,
  input  logic [TagW-1:0]  dma_wr_cmd_tag,
  output logic             dma_wr_resp_valid,
  output logic [LineW-1:0] dma_wr_resp_data,
  output logic [TagW-1:0]  dma_wr_resp_tag,
  output logic [1:0]       dma_wr_resp_pos,
  output logic [2:0]       dma_wr_resp_code,
  input  logic             dma_rd_cmd_valid,
  output logic             dma_rd_cmd_ready,
  input  logic [LineW-1:0] dma_rd_cmd_data,
  input  logic [BeW-1:0]   dma_rd_cmd_be,
  input  logic [EaW-1:0]   dma_rd_cmd_ea,
  input  logic [TagW-1:0]  dma_rd_cmd_tag,
  output logic             dma_rd_resp_valid,
  output logic [LineW-1:0] dma_rd_resp_data,
  output logic [TagW-1:0]  dma_rd_resp_tag,
  output logic [1:0]       dma_rd_resp_pos,
  output logic [2:0]       dma_rd_resp_code,
  output logic             idle
);

  localparam int unsigned CntW = $clog2(MAX_OUT + 1);

  // Low through reset so ready stays low until the first clock after release.
  logic                init_q;
  logic [CntW-1:0]     wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
  logic [NumTags-1:0]  wr_busy_q, wr_busy_d, rd_busy_q, rd_busy_d;
  logic [LineW-1:0]    mem_q [NumLines];

  logic                wr_accept, rd_accept;
  logic [IdxW-1:0]     wr_idx, rd_idx;
  logic                wr_in_window, rd_in_window;
  logic                wr_rsp_clr, rd_rsp_clr;
  logic                wr_tag_busy, rd_tag_busy;
  rsp_code_e           wr_code, rd_code;
  rsp_code_e           wr_rsp_code, rd_rsp_code;
  logic [LineW-1:0]    rd_line;

  assign dma_wr_cmd_ready = init_q && (wr_cnt_q < CntW'(MAX_OUT));
  assign dma_rd_cmd_ready = init_q && (rd_cnt_q < CntW'(MAX_OUT));

  assign wr_accept = dma_wr_cmd_valid && dma_wr_cmd_ready;
  assign rd_accept = dma_rd_cmd_valid && dma_rd_cmd_ready;

  assign wr_idx = dma_wr_cmd_ea[10:7];
  assign rd_idx = dma_rd_cmd_ea[10:7];

  assign wr_in_window = (dma_wr_cmd_ea[63:11] == BASE_EA);
  assign rd_in_window = (dma_rd_cmd_ea[63:11] == BASE_EA);

  // Only good responses own a bitmap bit; error responses must not free the
  // bit held by the original in-flight command with the same tag.
  assign wr_rsp_clr = dma_wr_resp_valid && (wr_rsp_code == RspOk);
  assign rd_rsp_clr = dma_rd_resp_valid && (rd_rsp_code == RspOk);

  // A tag whose response leaves this cycle is no longer in flight.
  assign wr_tag_busy = wr_busy_q[dma_wr_cmd_tag] &&
                       !(wr_rsp_clr && (dma_wr_resp_tag == dma_wr_cmd_tag));
  assign rd_tag_busy = rd_busy_q[dma_rd_cmd_tag] &&
                       !(rd_rsp_clr && (dma_rd_resp_tag == dma_rd_cmd_tag));

  always_comb begin
    wr_code = RspOk;
    if (!wr_in_window) begin
      wr_code = RspAddrErr;
    end else if (wr_tag_busy) begin
      wr_code = RspDupTag;
    end
    rd_code = RspOk;
    if (!rd_in_window) begin
      rd_code = RspAddrErr;
    end else if (rd_tag_busy) begin
      rd_code = RspDupTag;
    end
  end

  // Reads sample the registered array, so a same-cycle write to the line is
  // not yet visible and the read returns pre-write data.
  assign rd_line = (rd_accept && (rd_code == RspOk)) ? mem_q[rd_idx] : '0;

  always_comb begin
    wr_cnt_d = wr_cnt_q;
    if (wr_accept && !dma_wr_resp_valid) begin
      wr_cnt_d = wr_cnt_q + CntW'(1);
    end else if (!wr_accept && dma_wr_resp_valid) begin
      wr_cnt_d = wr_cnt_q - CntW'(1);
    end
    rd_cnt_d = rd_cnt_q;
    if (rd_accept && !dma_rd_resp_valid) begin
      rd_cnt_d = rd_cnt_q + CntW'(1);
    end else if (!rd_accept && dma_rd_resp_valid) begin
      rd_cnt_d = rd_cnt_q - CntW'(1);
    end

    wr_busy_d = wr_busy_q;
    if (wr_rsp_clr) begin
      wr_busy_d[dma_wr_resp_tag] = 1'b0;
    end
    if (wr_accept && (wr_code == RspOk)) begin
      wr_busy_d[dma_wr_cmd_tag] = 1'b1;
    end
    rd_busy_d = rd_busy_q;
    if (rd_rsp_clr) begin
      rd_busy_d[dma_rd_resp_tag] = 1'b0;
    end
    if (rd_accept && (rd_code == RspOk)) begin
      rd_busy_d[dma_rd_cmd_tag] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_q    <= 1'b0;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      wr_busy_q <= '0;
      rd_busy_q <= '0;
    end else begin
      init_q    <= 1'b1;
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      wr_busy_q <= wr_busy_d;
      rd_busy_q <= rd_busy_d;
    end
  end

  // Line memory is not reset; contents persist across a mid-run reset.
  always_ff @(posedge clk) begin
    if (wr_accept && (wr_code == RspOk)) begin
      for (int unsigned b = 0; b < BeW; b++) begin
        if (dma_wr_cmd_be[b]) begin
          mem_q[wr_idx][b*8 +: 8] <= dma_wr_cmd_data[b*8 +: 8];
        end
      end
    end
  end

  dma_lb_delay_line #(
    .Lat (RSP_LAT)
  ) u_wr_delay (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (wr_accept),
    .in_tag_i    (dma_wr_cmd_tag),
    .in_code_i   (wr_code),
    .in_data_i   ('0),
    .out_valid_o (dma_wr_resp_valid),
    .out_tag_o   (dma_wr_resp_tag),
    .out_code_o  (wr_rsp_code),
    .out_data_o  (dma_wr_resp_data)
  );

  dma_lb_delay_line #(
    .Lat (RSP_LAT)
  ) u_rd_delay (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (rd_accept),
    .in_tag_i    (dma_rd_cmd_tag),
    .in_code_i   (rd_code),
    .in_data_i   (rd_line),
    .out_valid_o (dma_rd_resp_valid),
    .out_tag_o   (dma_rd_resp_tag),
    .out_code_o  (rd_rsp_code),
    .out_data_o  (dma_rd_resp_data)
  );

  assign dma_wr_resp_code = wr_rsp_code;
  assign dma_rd_resp_code = rd_rsp_code;
  assign dma_wr_resp_pos  = PosFullLine;
  assign dma_rd_resp_pos  = PosFullLine;

  assign idle = (wr_cnt_q == '0) && (rd_cnt_q == '0);

  // Read payload/enables and the in-line offset bits carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{dma_rd_cmd_data, dma_rd_cmd_be,
                         dma_wr_cmd_ea[6:0], dma_rd_cmd_ea[6:0]};

endmodule
